// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with valid/ready output handshake.
// Oversamples the line with a baud counter and samples near each bit centre.
// Optional even-parity support is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       ready,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       overrun,
    output logic       parity_err
`else
    output logic       overrun
`endif
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            deliver;
    logic            rx_meta_q, rxs_q, rxs_prev_q;
`ifdef UART_RX_PARITY_EN
    logic            par_bad_q, par_bad_d;
    logic            parity_err_q, parity_err_d;
`endif

    // Two-flop synchronizer plus one extra stage for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rx_meta_q  <= rx;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    // Receiver state, counters and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_q        <= 3'd0;
            shreg_q      <= 8'h00;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Next-state: frame sequencing, bit capture and output handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif

        case (state_q)
            StIdle: begin
                if (rxs_prev_q && !rxs_q) begin
                    // The edge cycle is count 0 of the start bit; when the
                    // half-bit point is 0 that cycle is itself the start sample.
                    if (HALF == '0) begin
                        state_d = StData;
                        cnt_d   = '0;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = StStart;
                        cnt_d   = CW'(1);
                    end
                end
            end
            StStart: begin
                if (cnt_q == HALF) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    // Line back high at mid start bit: treat as a glitch.
                    state_d = rxs_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StData: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rxs_q, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_q == LAST) begin
                    cnt_d     = '0;
                    par_bad_d = ^{shreg_q, rxs_q};
                    state_d   = StStop;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            StStop: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (!rxs_q) begin
                        frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
`endif
                    end else begin
                        deliver = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Consumption first, so a same-cycle delivery can refill the slot.
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (deliver) begin
            if (!valid_q || ready) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed tests for uart_rx at CLKS_PER_BIT=1 and CLKS_PER_BIT=16.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // Slow instance (16 clocks per bit)
    logic       s_rx = 1'b1;
    logic       s_ready = 1'b1;
    logic [7:0] s_data;
    logic       s_valid, s_fe, s_ov;
    // Fast instance (1 clock per bit)
    logic       f_rx = 1'b1;
    logic       f_ready = 1'b1;
    logic [7:0] f_data;
    logic       f_valid, f_fe, f_ov;
`ifdef UART_RX_PARITY_EN
    logic       s_pe, f_pe;
`endif

    int errors = 0;
    int checks = 0;

    // Monitor state, only written by the monitors below
    logic [7:0] s_log [0:255];
    int s_wr = 0;
    int s_fe_cnt = 0;
    int s_ov_cnt = 0;
    int f_vcnt = 0;
    int f_fe_cnt = 0;
    int f_ov_cnt = 0;
    logic [7:0] f_last = 8'h00;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(16)) u_slow (
        .clk       (clk),
        .rst       (rst),
        .rx        (s_rx),
        .ready     (s_ready),
        .data      (s_data),
        .valid     (s_valid),
        .frame_err (s_fe),
`ifdef UART_RX_PARITY_EN
        .overrun   (s_ov),
        .parity_err(s_pe)
`else
        .overrun   (s_ov)
`endif
    );

    uart_rx #(.CLKS_PER_BIT(1)) u_fast (
        .clk       (clk),
        .rst       (rst),
        .rx        (f_rx),
        .ready     (f_ready),
        .data      (f_data),
        .valid     (f_valid),
        .frame_err (f_fe),
`ifdef UART_RX_PARITY_EN
        .overrun   (f_ov),
        .parity_err(f_pe)
`else
        .overrun   (f_ov)
`endif
    );

    // Record accepted bytes and flag pulses, sampled on the falling edge.
    always @(negedge clk) begin
        if (s_valid && s_ready) begin
            s_log[s_wr % 256] <= s_data;
            s_wr <= s_wr + 1;
        end
        if (s_fe) s_fe_cnt <= s_fe_cnt + 1;
        if (s_ov) s_ov_cnt <= s_ov_cnt + 1;
        if (f_valid) begin
            f_vcnt <= f_vcnt + 1;
            f_last <= f_data;
        end
        if (f_fe) f_fe_cnt <= f_fe_cnt + 1;
        if (f_ov) f_ov_cnt <= f_ov_cnt + 1;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame on the slow line; line is left at the stop-bit level.
    task automatic send_slow(input logic [7:0] b, input logic stop);
        s_rx = 1'b0;
        wait_cyc(16);
        for (int i = 0; i < 8; i++) begin
            s_rx = b[i];
            wait_cyc(16);
        end
`ifdef UART_RX_PARITY_EN
        s_rx = ^b;
        wait_cyc(16);
`endif
        s_rx = stop;
        wait_cyc(16);
    endtask

    task automatic test_reset;
        wait_cyc(2);
        checks++; if (s_data !== 8'h00) begin errors++; $display("FAIL reset_s_data got=%h exp=00", s_data); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid got=%b exp=0", s_valid); end
        checks++; if (s_fe !== 1'b0) begin errors++; $display("FAIL reset_s_fe got=%b exp=0", s_fe); end
        checks++; if (s_ov !== 1'b0) begin errors++; $display("FAIL reset_s_ov got=%b exp=0", s_ov); end
        checks++; if (f_data !== 8'h00) begin errors++; $display("FAIL reset_f_data got=%h exp=00", f_data); end
        checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL reset_f_valid got=%b exp=0", f_valid); end
        rst = 1'b0;
        wait_cyc(5);
    endtask

    task automatic test_fast_byte;
        logic [7:0] b;
        int v0;
        b = 8'h48;
        v0 = f_vcnt;
        f_ready = 1'b1;
        f_rx = 1'b0;
        wait_cyc(1);
        for (int i = 0; i < 8; i++) begin
            f_rx = b[i];
            wait_cyc(1);
        end
        f_rx = 1'b1;
        wait_cyc(10);
        checks++; if (f_vcnt - v0 !== 1) begin errors++; $display("FAIL fast_valid_cycles got=%0d exp=1", f_vcnt - v0); end
        checks++; if (f_last !== 8'h48) begin errors++; $display("FAIL fast_data got=%h exp=48", f_last); end
        checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL fast_valid_after got=%b exp=0", f_valid); end
        checks++; if (f_fe_cnt !== 0) begin errors++; $display("FAIL fast_frame_err got=%0d exp=0", f_fe_cnt); end
        checks++; if (f_ov_cnt !== 0) begin errors++; $display("FAIL fast_overrun got=%0d exp=0", f_ov_cnt); end
    endtask

    task automatic test_hello;
        logic [7:0] msg [13];
        int w0, fe0, ov0;
        msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};
        w0 = s_wr; fe0 = s_fe_cnt; ov0 = s_ov_cnt;
        s_ready = 1'b1;
        for (int i = 0; i < 13; i++) send_slow(msg[i], 1'b1);
        s_rx = 1'b1;
        wait_cyc(20);
        checks++; if (s_wr - w0 !== 13) begin errors++; $display("FAIL hello_count got=%0d exp=13", s_wr - w0); end
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (s_log[(w0 + i) % 256] !== msg[i]) begin
                errors++;
                $display("FAIL hello_byte%0d got=%h exp=%h", i, s_log[(w0 + i) % 256], msg[i]);
            end
        end
        checks++; if (s_fe_cnt - fe0 !== 0) begin errors++; $display("FAIL hello_fe got=%0d exp=0", s_fe_cnt - fe0); end
        checks++; if (s_ov_cnt - ov0 !== 0) begin errors++; $display("FAIL hello_ov got=%0d exp=0", s_ov_cnt - ov0); end
    endtask

    task automatic test_overrun;
        int w0, ov0;
        w0 = s_wr; ov0 = s_ov_cnt;
        s_ready = 1'b0;
        send_slow(8'h41, 1'b1);
        send_slow(8'h42, 1'b1);
        s_rx = 1'b1;
        wait_cyc(10);
        checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held got=%b exp=1", s_valid); end
        checks++; if (s_data !== 8'h41) begin errors++; $display("FAIL ovr_data_kept got=%h exp=41", s_data); end
        checks++; if (s_ov_cnt - ov0 !== 1) begin errors++; $display("FAIL ovr_pulses got=%0d exp=1", s_ov_cnt - ov0); end
        s_ready = 1'b1;
        wait_cyc(1);
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_clear got=%b exp=0", s_valid); end
        checks++; if (s_log[w0 % 256] !== 8'h41 || s_wr - w0 !== 1) begin
            errors++; $display("FAIL ovr_consumed got=%h n=%0d exp=41 n=1", s_log[w0 % 256], s_wr - w0);
        end
    endtask

    task automatic test_frame_err;
        int w0, fe0, ov0;
        w0 = s_wr; fe0 = s_fe_cnt; ov0 = s_ov_cnt;
        s_ready = 1'b1;
        send_slow(8'h55, 1'b0);
        wait_cyc(100);
        s_rx = 1'b1;
        wait_cyc(40);
        checks++; if (s_fe_cnt - fe0 !== 1) begin errors++; $display("FAIL ferr_pulse_cycles got=%0d exp=1", s_fe_cnt - fe0); end
        checks++; if (s_wr - w0 !== 0) begin errors++; $display("FAIL ferr_no_byte got=%0d exp=0", s_wr - w0); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid got=%b exp=0", s_valid); end
        checks++; if (s_ov_cnt - ov0 !== 0) begin errors++; $display("FAIL ferr_ov got=%0d exp=0", s_ov_cnt - ov0); end
    endtask

    task automatic test_glitch;
        int w0, fe0, ov0;
        w0 = s_wr; fe0 = s_fe_cnt; ov0 = s_ov_cnt;
        s_rx = 1'b0;
        wait_cyc(3);
        s_rx = 1'b1;
        wait_cyc(200);
        checks++; if (s_wr - w0 !== 0) begin errors++; $display("FAIL glitch_no_byte got=%0d exp=0", s_wr - w0); end
        checks++; if (s_fe_cnt - fe0 !== 0) begin errors++; $display("FAIL glitch_fe got=%0d exp=0", s_fe_cnt - fe0); end
        checks++; if (s_ov_cnt - ov0 !== 0) begin errors++; $display("FAIL glitch_ov got=%0d exp=0", s_ov_cnt - ov0); end
        send_slow(8'h5A, 1'b1);
        s_rx = 1'b1;
        wait_cyc(20);
        checks++; if (s_wr - w0 !== 1 || s_log[w0 % 256] !== 8'h5A) begin
            errors++; $display("FAIL glitch_recover got=%h n=%0d exp=5A n=1", s_log[w0 % 256], s_wr - w0);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] b;
        int w0, fe0, ov0;
        b = 8'hA5;
        s_rx = 1'b0;
        wait_cyc(16);
        for (int i = 0; i < 4; i++) begin
            s_rx = b[i];
            wait_cyc(16);
        end
        s_rx = b[4];
        wait_cyc(8);
        rst = 1'b1;
        s_rx = 1'b1;
        wait_cyc(2);
        checks++; if (s_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got=%h exp=00", s_data); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", s_valid); end
        checks++; if (s_fe !== 1'b0 || s_ov !== 1'b0) begin
            errors++; $display("FAIL rstmid_flags got=%b%b exp=00", s_fe, s_ov);
        end
        rst = 1'b0;
        wait_cyc(2);
        w0 = s_wr; fe0 = s_fe_cnt; ov0 = s_ov_cnt;
        wait_cyc(40);
        send_slow(8'h3C, 1'b1);
        s_rx = 1'b1;
        wait_cyc(20);
        checks++; if (s_wr - w0 !== 1) begin errors++; $display("FAIL rstmid_count got=%0d exp=1", s_wr - w0); end
        checks++; if (s_log[w0 % 256] !== 8'h3C) begin errors++; $display("FAIL rstmid_byte got=%h exp=3C", s_log[w0 % 256]); end
        checks++; if (s_fe_cnt - fe0 !== 0 || s_ov_cnt - ov0 !== 0) begin
            errors++; $display("FAIL rstmid_noflags fe=%0d ov=%0d exp=0 0", s_fe_cnt - fe0, s_ov_cnt - ov0);
        end
    endtask

    initial begin
        test_reset;
        test_fast_byte;
        test_hello;
        test_overrun;
        test_frame_err;
        test_glitch;
        test_reset_mid_frame;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
